commit_trace_sink: RTL and testbench

//  Consumer end of the core's commit trace (commit_valid/pc/rd/data from the debug wrapper).

---
 rtl/commit_trace_pkg.sv | 19 +
 rtl/commit_trace_fifo.sv | 60 ++++++
 rtl/commit_trace_sink.sv | 141 ++++++++++++++
 tb/tb_commit_trace_sink.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// rtl/commit_trace_pkg.sv - shared record type and framing constants for the commit trace sink
// COMMIT_TRACE_SEQ_EN selects the 10-byte record carrying a sequence byte.
package commit_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } commit_rec_t;

  localparam logic HDR_MARK    = 1'b1;
  localparam int   HDR_OVF_BIT = 6;
`ifdef COMMIT_TRACE_SEQ_EN
  localparam int   REC_BYTES   = 10;
`else
  localparam int   REC_BYTES   = 9;
`endif

endpackage

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - synchronous record FIFO for the commit trace sink
// With COMMIT_TRACE_SEQ_EN each entry also carries the commit's sequence byte.
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  commit_rec_t      wr_rec,
`ifdef COMMIT_TRACE_SEQ_EN
  input  logic [7:0]       wr_seq,
  output logic [7:0]       rd_seq,
`endif
  output commit_rec_t      rd_rec,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  commit_rec_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is not reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

`ifdef COMMIT_TRACE_SEQ_EN
  logic [7:0] seq_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (push) seq_mem[wr_ptr] <= wr_seq;
  end
  assign rd_seq = seq_mem[rd_ptr];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  assign rd_rec = mem[rd_ptr];
  assign full   = (level == LVL_W'(DEPTH));
  assign empty  = (level == '0);

endmodule

// File: rtl/commit_trace_sink.sv
// rtl/commit_trace_sink.sv - captures retired register writes and serialises them as trace bytes
// COMMIT_TRACE_SEQ_EN inserts an 8-bit sequence byte after each record header.
module commit_trace_sink
  import commit_trace_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DROP_W    = 16,
  parameter int FILTER_X0 = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       commit_valid,
  input  logic [31:0]                commit_pc,
  input  logic [4:0]                 commit_rd,
  input  logic [31:0]                commit_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_byte,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int         LVL_W    = $clog2(DEPTH + 1);
  localparam logic [3:0] LAST_IDX = 4'(REC_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic        ovf;
  commit_rec_t head;
  commit_rec_t wr_rec;
  logic        full, empty;
  logic        accepted, xfer, last_xfer, push, pop, drop;
  logic [7:0]  hdr;
  logic [63:0] body;
  logic [2:0]  body_idx;

  assign accepted  = commit_valid && !((FILTER_X0 != 0) && (commit_rd == 5'd0));
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);
  assign pop       = last_xfer && !empty;
  // A slot freed by the final byte this edge can take the incoming commit.
  assign push      = accepted && (!full || pop);
  assign drop      = accepted && full && !pop;
  assign wr_rec    = '{pc: commit_pc, rd: commit_rd, data: commit_data};

`ifdef COMMIT_TRACE_SEQ_EN
  logic [7:0] seq;
  logic [7:0] head_seq;

  // Dropped commits still consume a number so the host can see the gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         seq <= 8'd0;
    else if (accepted) seq <= seq + 8'd1;
  end
`endif

  commit_trace_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_rec (wr_rec),
`ifdef COMMIT_TRACE_SEQ_EN
    .wr_seq (seq),
    .rd_seq (head_seq),
`endif
    .rd_rec (head),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      idx       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state     <= SEND;
            out_valid <= 1'b1;
            idx       <= 4'd0;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              idx <= 4'd0;
              if (!push && fifo_level <= LVL_W'(1)) begin
                state     <= IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Set beats clear so a drop during the header transfer flags the following record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf        <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop)                          ovf <= 1'b1;
      else if (xfer && idx == 4'd0)      ovf <= 1'b0;
      if (drop && drop_count != '1)      drop_count <= drop_count + 1'b1;
    end
  end

  assign body     = {head.data, head.pc};
  assign body_idx = 3'(idx - 4'(REC_BYTES - 8));

  always_comb begin
    hdr              = {HDR_MARK, 2'b00, head.rd};
    hdr[HDR_OVF_BIT] = ovf;
  end

  always_comb begin
    out_byte = 8'h00;
    if (out_valid) begin
      if (idx == 4'd0) out_byte = hdr;
`ifdef COMMIT_TRACE_SEQ_EN
      else if (idx == 4'd1) out_byte = head_seq;
`endif
      else out_byte = body[{body_idx, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_commit_trace_sink.sv
// tb/tb_commit_trace_sink.sv - randomized self-checking bench for commit_trace_sink
// Builds with or without COMMIT_TRACE_SEQ_EN.
module tb_commit_trace_sink;

`ifdef COMMIT_TRACE_SEQ_EN
  localparam int REC = 10;
`else
  localparam int REC = 9;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [7:0]  seq;
  } rec_t;

  rec_t       mq[$];
  int         m_pos;
  bit         m_ovf;
  int         m_drop;
  logic [7:0] m_seq;

  commit_trace_sink #(.DEPTH(DEPTH), .DROP_W(16), .FILTER_X0(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_byte     (out_byte),
    .fifo_level   (fifo_level),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rec_byte(rec_t r, int i, bit ovf);
    int j;
    j = i;
    if (i == 0) return {1'b1, ovf, 1'b0, r.rd};
`ifdef COMMIT_TRACE_SEQ_EN
    if (i == 1) return r.seq;
    j = i - 1;
`endif
    if (j <= 4) return 8'((r.pc >> (8 * (j - 1))) & 32'hFF);
    return 8'((r.data >> (8 * (j - 5))) & 32'hFF);
  endfunction

  function automatic logic [7:0] exp_byte();
    if (mq.size() == 0) return 8'h00;
    return rec_byte(mq[0], m_pos, m_ovf);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pos  = 0;
    m_ovf  = 0;
    m_drop = 0;
    m_seq  = 8'd0;
  endtask

  // Applies one clock edge to the reference model using the inputs currently driven.
  task automatic model_edge();
    bit   xfer, last, acc;
    rec_t r;
    @(posedge clk);
    xfer = (mq.size() != 0) && out_ready;
    last = xfer && (m_pos == REC - 1);
    acc  = commit_valid && (commit_rd != 5'd0);
    if (xfer && m_pos == 0) m_ovf = 0;
    if (xfer) begin
      if (last) begin
        void'(mq.pop_front());
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    if (acc) begin
      if (mq.size() < DEPTH) begin
        r.pc = commit_pc; r.rd = commit_rd; r.data = commit_data; r.seq = m_seq;
        mq.push_back(r);
      end else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      m_seq = m_seq + 8'd1;
    end
  endtask

  task automatic rand_commit(input bit allow_x0);
    commit_valid = 1'b1;
    commit_pc    = $urandom;
    commit_data  = $urandom;
    commit_rd    = allow_x0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31));
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (out_valid !== 1'b0 || out_byte !== 8'h00 || fifo_level !== 3'd0 || drop_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: got v=%0b byte=%02h lvl=%0d drop=%0d, expected all zero",
               out_valid, out_byte, fifo_level, drop_count);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [7:0] exp_q[$];
    exp_q = {8'h84};
`ifdef COMMIT_TRACE_SEQ_EN
    exp_q.push_back(8'h00);
`endif
    exp_q = {exp_q, 8'h10, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    @(negedge clk);
    commit_valid = 1'b1; commit_pc = 32'h0000_0010; commit_rd = 5'd4; commit_data = 32'hFFFF_FFFE;
    out_ready = 1'b1;
    model_edge();
    for (int i = 0; i < REC; i++) begin
      @(negedge clk);
      commit_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_byte !== exp_q[i]) begin
        fails++;
        $display("FAIL single_byte%0d: got v=%0b byte=%02h, expected v=1 byte=%02h", i, out_valid, out_byte, exp_q[i]);
      end
      tests++;
      if (out_byte !== exp_byte() || fifo_level !== 3'(mq.size()) || drop_count !== 16'(m_drop)) begin
        fails++;
        $display("FAIL single_model: got byte=%02h lvl=%0d drop=%0d, expected byte=%02h lvl=%0d drop=%0d",
                 out_byte, fifo_level, drop_count, exp_byte(), mq.size(), m_drop);
      end
      model_edge();
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      fails++;
      $display("FAIL single_end: got v=%0b lvl=%0d, expected v=0 lvl=0", out_valid, fifo_level);
    end
  endtask

  task automatic test_random_ready();
    int         n = 0;
    bit         prev_v = 0, prev_r = 0;
    logic [7:0] prev_b = 8'h00;
    for (int c = 0; c < 300 && !(n >= 3 && mq.size() == 0); c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== (mq.size() != 0) || out_byte !== exp_byte() || fifo_level !== 3'(mq.size()) || drop_count !== 16'(m_drop)) begin
        fails++;
        $display("FAIL rand_ready t=%0t: got v=%0b byte=%02h lvl=%0d drop=%0d, expected v=%0b byte=%02h lvl=%0d drop=%0d",
                 $time, out_valid, out_byte, fifo_level, drop_count, mq.size() != 0, exp_byte(), mq.size(), m_drop);
      end
      if (prev_v && !prev_r) begin
        tests++;
        if (out_valid !== 1'b1 || out_byte !== prev_b) begin
          fails++;
          $display("FAIL stall_hold t=%0t: got v=%0b byte=%02h, expected v=1 byte=%02h", $time, out_valid, out_byte, prev_b);
        end
      end
      prev_v = out_valid; prev_b = out_byte;
      if (n < 3) begin rand_commit(0); n++; end
      else commit_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      prev_r = out_ready;
      model_edge();
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      fails++;
      $display("FAIL rand_ready_drain: got v=%0b model_left=%0d, expected v=0 model_left=0", out_valid, mq.size());
    end
  endtask

  task automatic test_full_drop();
    logic [7:0] hdrs[$];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      rand_commit(0);
      model_edge();
    end
    @(negedge clk);
    commit_valid = 1'b0;
    tests++;
    if (fifo_level !== 3'd4 || drop_count !== 16'd2 || out_byte[6] !== 1'b1) begin
      fails++;
      $display("FAIL full_drop: got lvl=%0d drop=%0d hdr_ovf=%0b, expected lvl=4 drop=2 hdr_ovf=1",
               fifo_level, drop_count, out_byte[6]);
    end
    for (int c = 0; c < 100 && mq.size() != 0; c++) begin
      if (c != 0) @(negedge clk);
      tests++;
      if (out_valid !== (mq.size() != 0) || out_byte !== exp_byte() || fifo_level !== 3'(mq.size()) || drop_count !== 16'(m_drop)) begin
        fails++;
        $display("FAIL full_drain t=%0t: got v=%0b byte=%02h lvl=%0d drop=%0d, expected v=%0b byte=%02h lvl=%0d drop=%0d",
                 $time, out_valid, out_byte, fifo_level, drop_count, mq.size() != 0, exp_byte(), mq.size(), m_drop);
      end
      if (out_valid && m_pos == 0) hdrs.push_back(out_byte);
      out_ready = 1'b1;
      model_edge();
    end
    tests++;
    if (hdrs.size() < 2 || hdrs[0][6] !== 1'b1 || hdrs[1][6] !== 1'b0) begin
      fails++;
      $display("FAIL ovf_headers: got count=%0d first=%02h second=%02h, expected first bit6=1 second bit6=0",
               hdrs.size(), hdrs.size() > 0 ? hdrs[0] : 8'h00, hdrs.size() > 1 ? hdrs[1] : 8'h00);
    end
  endtask

  task automatic test_full_pop_coincide();
    bit done = 0;
    int saved_drop;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      rand_commit(0);
      model_edge();
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== (mq.size() != 0) || out_byte !== exp_byte() || fifo_level !== 3'(mq.size()) || drop_count !== 16'(m_drop)) begin
        fails++;
        $display("FAIL coincide_cycle t=%0t: got v=%0b byte=%02h lvl=%0d drop=%0d, expected v=%0b byte=%02h lvl=%0d drop=%0d",
                 $time, out_valid, out_byte, fifo_level, drop_count, mq.size() != 0, exp_byte(), mq.size(), m_drop);
      end
      out_ready = 1'b1;
      commit_valid = 1'b0;
      if (mq.size() == DEPTH && m_pos == REC - 1) begin
        rand_commit(0);
        saved_drop = m_drop;
        done = 1;
      end
      model_edge();
    end
    @(negedge clk);
    commit_valid = 1'b0;
    tests++;
    if (!done || drop_count !== 16'(saved_drop) || fifo_level !== 3'd4) begin
      fails++;
      $display("FAIL coincide: got reached=%0b drop=%0d lvl=%0d, expected reached=1 drop=%0d lvl=4",
               done, drop_count, fifo_level, saved_drop);
    end
    for (int c = 0; c < 100 && mq.size() != 0; c++) begin
      if (c != 0) @(negedge clk);
      model_edge();
    end
  endtask

  task automatic test_filter_x0();
    int saved_drop;
    @(negedge clk);
    saved_drop = m_drop;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      rand_commit(0);
      commit_rd = 5'd0;
      out_ready = 1'b1;
      model_edge();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      commit_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0 || drop_count !== 16'(saved_drop)) begin
        fails++;
        $display("FAIL filter_x0: got v=%0b lvl=%0d drop=%0d, expected v=0 lvl=0 drop=%0d",
                 out_valid, fifo_level, drop_count, saved_drop);
      end
      model_edge();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== (mq.size() != 0) || out_byte !== exp_byte() || fifo_level !== 3'(mq.size()) || drop_count !== 16'(m_drop)) begin
        fails++;
        $display("FAIL back_to_back t=%0t: got v=%0b byte=%02h lvl=%0d drop=%0d, expected v=%0b byte=%02h lvl=%0d drop=%0d",
                 $time, out_valid, out_byte, fifo_level, drop_count, mq.size() != 0, exp_byte(), mq.size(), m_drop);
      end
      if (c < 400 && $urandom_range(0, 2) != 0) rand_commit(1);
      else commit_valid = 1'b0;
      out_ready = (c >= 400) ? 1'b1 : 1'($urandom_range(0, 1));
      model_edge();
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || mq.size() != 0) begin
      fails++;
      $display("FAIL back_to_back_drain: got v=%0b lvl=%0d model_left=%0d, expected v=0 lvl=0 model_left=0",
               out_valid, fifo_level, mq.size());
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      rand_commit(0);
      model_edge();
    end
    @(negedge clk);
    commit_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || drop_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_midrun: got v=%0b lvl=%0d drop=%0d, expected v=0 lvl=0 drop=0",
               out_valid, fifo_level, drop_count);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef COMMIT_TRACE_SEQ_EN
  task automatic test_seq();
    @(negedge clk);
    reset = 1'b1;
    commit_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 257; k++) begin
      @(negedge clk);
      rand_commit(0);
      out_ready = 1'b1;
      model_edge();
      for (int i = 0; i < REC; i++) begin
        @(negedge clk);
        commit_valid = 1'b0;
        if (m_pos == 1) begin
          tests++;
          if (out_valid !== 1'b1 || out_byte !== 8'(k)) begin
            fails++;
            $display("FAIL seq_byte k=%0d: got v=%0b byte=%02h, expected v=1 byte=%02h", k, out_valid, out_byte, 8'(k));
          end
        end
        model_edge();
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    commit_valid = 1'b0;
    commit_pc = 32'd0;
    commit_rd = 5'd0;
    commit_data = 32'd0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_random_ready();
    test_full_drop();
    test_full_pop_coincide();
    test_filter_x0();
    test_back_to_back();
    test_reset_midrun();
    test_single();
`ifdef COMMIT_TRACE_SEQ_EN
    test_seq();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
